// File: rtl/miriscv_uart_pkg.sv
// Shared constants for the miriscv UART transmitter: register map, STATUS bits, FSM states.
package miriscv_uart_pkg;

  localparam int unsigned UART_DEFAULT_DIV = 868;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/miriscv_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module miriscv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);
  assign cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/miriscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, read pipeline, TX FIFO, baud counter and FSM.
module miriscv_uart_tx
  import miriscv_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        tx_o
);

  logic [DIV_W-1:0] bauddiv_q, bauddiv_d;
  logic [DIV_W-1:0] div_q, div_d, baud_cnt_q, baud_cnt_d, div_eff;
  logic             ovf_q, ovf_d, ovf_clr, ovf_set;
  logic             rvalid_q;
  logic [31:0]      rdata_q, rdata_d;
  tx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             tx_q, tx_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [1:0]       reg_sel;
  logic             wr_en, rd_en, busy, period_end, load;
  logic             unused_ok;

  assign reg_sel    = addr_i[3:2];
  assign wr_en      = req_i && we_i;
  assign rd_en      = req_i && !we_i;
  assign fifo_push  = wr_en && (reg_sel == REG_TXDATA) && be_i[0];
  assign ovf_clr    = wr_en && (reg_sel == REG_STATUS) && be_i[0] && wdata_i[3];
  assign ovf_set    = fifo_push && fifo_full && !fifo_pop;
  assign busy       = (state_q != S_IDLE);
  assign div_eff    = (bauddiv_q == '0) ? DIV_W'(1) : bauddiv_q;
  assign period_end = (baud_cnt_q == '0);
  assign unused_ok  = ^{addr_i[31:4], addr_i[1:0], wdata_i, be_i};

  miriscv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Register writes and read-data mux.
  always_comb begin
    bauddiv_d = bauddiv_q;
    ovf_d     = (ovf_q && !ovf_clr) || ovf_set;
    rdata_d   = '0;
    if (wr_en && (reg_sel == REG_BAUDDIV)) begin
      for (int unsigned i = 0; i < DIV_W; i++) begin
        if (be_i[i/8]) bauddiv_d[i] = wdata_i[i];
      end
    end
    if (rd_en) begin
      case (reg_sel)
        REG_STATUS: begin
          rdata_d[ST_FULL]  = fifo_full;
          rdata_d[ST_EMPTY] = fifo_empty;
          rdata_d[ST_BUSY]  = busy;
          rdata_d[ST_OVF]   = ovf_q;
        end
        REG_BAUDDIV: rdata_d = 32'(bauddiv_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  // Serialiser next-state; a frame's divider is latched when its byte is popped.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    tx_d       = 1'b1;
    if (state_q != S_IDLE) begin
      baud_cnt_d = period_end ? (div_q - DIV_W'(1)) : (baud_cnt_q - DIV_W'(1));
    end
    case (state_q)
      S_IDLE:  load = !fifo_empty;
      S_START: if (period_end) state_d = S_DATA;
      S_DATA: begin
        if (period_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (period_end) begin
          if (fifo_empty) state_d = S_IDLE;
          else            load    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_rdata;
      div_d      = div_eff;
      baud_cnt_d = div_eff - DIV_W'(1);
      bit_cnt_d  = '0;
      state_d    = S_START;
    end
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bauddiv_q  <= DIV_W'(DEFAULT_DIV);
      ovf_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      state_q    <= S_IDLE;
      div_q      <= DIV_W'(1);
      baud_cnt_q <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      bauddiv_q  <= bauddiv_d;
      ovf_q      <= ovf_d;
      rvalid_q   <= rd_en;
      rdata_q    <= rdata_d;
      state_q    <= state_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign tx_o     = tx_q;

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Directed bench for miriscv_uart_tx: register-access vector table plus serial-frame sequences.
module tb_miriscv_uart_tx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        tx_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  always #5 clk_i = ~clk_i;

  miriscv_uart_tx dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .tx_o     (tx_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected line level j cycles into a frame of byte b with bit period div.
  function automatic logic exp_tx(input logic [7:0] b, input int div, input int j);
    int idx;
    idx = j / div;
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else               return 1'b1;
  endfunction

  // Called at a negedge; drives one bus cycle and returns at the following negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = 4'hF;
    @(negedge clk_i);
    req_i = 1'b0; be_i = 4'h0;
    check({nm, "_rvalid"}, 32'(rvalid_o), 32'h1);
    check({nm, "_rdata"}, rdata_o, exp);
  endtask

  // Samples tx_o at successive negedges for frame cycles j0 .. 10*div-1.
  task automatic check_frame(input logic [7:0] b, input int div, input int j0, input string nm);
    for (int j = j0; j < 10 * div; j++) begin
      @(negedge clk_i);
      check($sformatf("%s_cyc%0d", nm, j), 32'(tx_o), 32'(exp_tx(b, div, j)));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [6];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

    vecs[0]  = '{1'b0, 32'h4,  32'h0,        4'h0, 32'h2};
    vecs[1]  = '{1'b0, 32'h8,  32'h0,        4'h0, 32'd868};
    vecs[2]  = '{1'b1, 32'h8,  32'h1234,     4'h1, 32'h0};
    vecs[3]  = '{1'b0, 32'h8,  32'h0,        4'h0, 32'h0334};
    vecs[4]  = '{1'b1, 32'h8,  32'hABCD,     4'h2, 32'h0};
    vecs[5]  = '{1'b0, 32'h8,  32'h0,        4'h0, 32'hAB34};
    vecs[6]  = '{1'b1, 32'h8,  32'hFFFF0005, 4'hF, 32'h0};
    vecs[7]  = '{1'b0, 32'h8,  32'h0,        4'h0, 32'h5};
    vecs[8]  = '{1'b1, 32'hC,  32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 32'hC,  32'h0,        4'h0, 32'h0};
    vecs[10] = '{1'b1, 32'h0,  32'hAA,       4'hE, 32'h0};
    vecs[11] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0};
    vecs[12] = '{1'b1, 32'h4,  32'hF,        4'hF, 32'h0};
    vecs[13] = '{1'b0, 32'h4,  32'h0,        4'h0, 32'h2};
    vecs[14] = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h2};

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_tx", 32'(tx_o), 32'h1);
    check("reset_rvalid", 32'(rvalid_o), 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    rst_i = 1'b0;

    // Register access table.
    for (int i = 0; i < 15; i++) begin
      req_i = 1'b1; we_i = vecs[i].we; addr_i = vecs[i].addr;
      wdata_i = vecs[i].wdata; be_i = vecs[i].be;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid_o), vecs[i].we ? 32'h0 : 32'h1);
      check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].we ? 32'h0 : vecs[i].exp);
      check($sformatf("vec%0d_tx", i), 32'(tx_o), 32'h1);
    end

    // Single frame at div 4, with the busy window edges probed.
    bus_write(32'h8, 32'd4, 4'hF);
    bus_write(32'h0, 32'hA5, 4'h1);
    check("a5_tx_before_pop", 32'(tx_o), 32'h1);
    fork
      check_frame(8'hA5, 4, 0, "a5");
      begin
        bus_read(32'h4, 32'h0, "a5_status_prebusy");
        repeat (39) @(negedge clk_i);
        bus_read(32'h4, 32'h6, "a5_status_lastbusy");
      end
    join
    bus_read(32'h4, 32'h2, "a5_status_after");

    // Back-to-back burst overflowing the FIFO at div 2.
    bus_write(32'h8, 32'd2, 4'hF);
    for (int i = 0; i < 6; i++) begin
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; be_i = 4'h1; wdata_i = 32'(burst[i]);
      @(negedge clk_i);
      if (i >= 1) check($sformatf("burst_b0_cyc%0d", i - 1), 32'(tx_o), 32'(exp_tx(burst[0], 2, i - 1)));
    end
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    check_frame(burst[0], 2, 5, "burst_b0");
    fork
      check_frame(burst[1], 2, 0, "burst_b1");
      begin
        repeat (4) @(negedge clk_i);
        bus_read(32'h4, 32'hC, "burst_status_mid");
      end
    join
    check_frame(burst[2], 2, 0, "burst_b2");
    check_frame(burst[3], 2, 0, "burst_b3");
    check_frame(burst[4], 2, 0, "burst_b4");
    @(negedge clk_i);
    check("burst_tx_idle", 32'(tx_o), 32'h1);
    bus_read(32'h4, 32'hA, "burst_status_ovf");
    bus_write(32'h4, 32'h8, 4'h1);
    bus_read(32'h4, 32'h2, "burst_status_cleared");

    // Divider change mid-frame only applies to the next frame.
    bus_write(32'h0, 32'h3C, 4'h1);
    fork
      check_frame(8'h3C, 2, 0, "divchg_f0");
      begin
        bus_write(32'h0, 32'hC3, 4'h1);
        bus_write(32'h8, 32'd8, 4'hF);
      end
    join
    check_frame(8'hC3, 8, 0, "divchg_f1");
    @(negedge clk_i);
    check("divchg_tx_idle", 32'(tx_o), 32'h1);

    // Reset in the middle of the data bits.
    bus_write(32'h0, 32'h00, 4'h1);
    repeat (28) @(negedge clk_i);
    check("midrst_tx_data", 32'(tx_o), 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_tx_high", 32'(tx_o), 32'h1);
    check("midrst_rvalid", 32'(rvalid_o), 32'h0);
    bus_read(32'h4, 32'h2, "midrst_status");
    bus_read(32'h8, 32'd868, "midrst_bauddiv");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check($sformatf("midrst_quiet%0d", i), 32'(tx_o), 32'h1);
    end

    // Divider 0 behaves as 1: contiguous 10-cycle frames.
    bus_write(32'h8, 32'd0, 4'hF);
    bus_write(32'h0, 32'h96, 4'h1);
    fork
      check_frame(8'h96, 1, 0, "div0_f0");
      bus_write(32'h0, 32'h0F, 4'h1);
    join
    check_frame(8'h0F, 1, 0, "div0_f1");
    @(negedge clk_i);
    check("div0_tx_idle", 32'(tx_o), 32'h1);
    bus_read(32'hC, 32'h0, "rsvd_read");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
